// File: rtl/autoenc_pkg.sv
// rtl/autoenc_pkg.sv - opcode map and sequencer state encoding for the autoencoder datapath
package autoenc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_MAC  = 4'h3;
    localparam logic [3:0] OP_RELU = 4'h4;
    localparam logic [3:0] OP_SIG  = 4'h5;
    localparam logic [3:0] OP_LOAD = 4'h6;
    localparam logic [3:0] OP_SIGD = 4'h7;
    localparam logic [3:0] OP_HALT = 4'h8;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_ADV    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - fetches instruction words from ROM and issues opcodes to the control unit
module inst_sequencer
    import autoenc_pkg::*;
#(
    parameter int OP_WIDTH   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int PC_WIDTH   = 8,
    parameter int EXEC_LAT   = 2,
    localparam int INSTR_W   = OP_WIDTH + 3 * ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    input  logic                  abort,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic [OP_WIDTH-1:0]   opcode_o,
    output logic [ADDR_WIDTH-1:0] dest_addr,
    output logic [ADDR_WIDTH-1:0] src1_addr,
    output logic [ADDR_WIDTH-1:0] src2_addr,
    output logic                  issue,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [PC_WIDTH-1:0]   pc
);

    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [CNT_W-1:0]    CNT_TOP = CNT_W'(EXEC_LAT - 1);
    localparam logic [PC_WIDTH-1:0] PC_LAST = '1;
    localparam logic [OP_WIDTH-1:0] OPC_NOP = OP_WIDTH'(OP_NOP);

    state_t               state, state_nxt;
    logic [INSTR_W-1:0]   ir;
    logic [CNT_W-1:0]     cnt;
    logic [OP_WIDTH-1:0]  dec_op;
    logic [OP_WIDTH-1:0]  opcode_nxt;
    logic                 issue_nxt;
    logic                 done_nxt;

    assign dec_op    = imem_rdata[INSTR_W-1 -: OP_WIDTH];
    assign dest_addr = ir[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src1_addr = ir[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src2_addr = ir[ADDR_WIDTH-1:0];
    assign imem_en   = (state == S_FETCH);
    assign imem_addr = pc;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_op == OP_WIDTH'(OP_HALT))
                    state_nxt = S_DONE;
                else if (dec_op <= OP_WIDTH'(OP_SIGD))
                    state_nxt = S_EXEC;
                else
                    state_nxt = S_ADV;
            end
            S_EXEC:   if (cnt == '0) state_nxt = S_ADV;
            S_ADV:    state_nxt = (pc == PC_LAST) ? S_DONE : S_FETCH;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // DONE already ends the run, so an abort there must not extend it.
        if (abort && state != S_IDLE && state != S_DONE)
            state_nxt = S_DONE;
    end

    // Output values are computed for the next state and then registered.
    always_comb begin
        opcode_nxt = OPC_NOP;
        issue_nxt  = 1'b0;
        done_nxt   = (state_nxt == S_DONE);
        if (state_nxt == S_EXEC) begin
            if (state == S_DECODE) begin
                opcode_nxt = dec_op;
                issue_nxt  = 1'b1;
            end else begin
                opcode_nxt = ir[INSTR_W-1 -: OP_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ir       <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            opcode_o <= OPC_NOP;
            issue    <= 1'b0;
            done     <= 1'b0;
        end else begin
            opcode_o <= opcode_nxt;
            issue    <= issue_nxt;
            done     <= done_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc  <= start_pc;
                        err <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (!abort) begin
                        ir  <= imem_rdata;
                        cnt <= CNT_TOP;
                    end
                end
                S_EXEC: begin
                    if (!abort && cnt != '0) cnt <= cnt - 1'b1;
                end
                S_ADV: begin
                    if (!abort) begin
                        if (pc == PC_LAST) err <= 1'b1;
                        else               pc  <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - scoreboard bench for inst_sequencer
module tb_inst_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic [7:0] d;
        logic [7:0] s1;
        logic [7:0] s2;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        abort = 1'b0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [27:0] imem_rdata = '0;
    logic [3:0]  opcode_o;
    logic [7:0]  dest_addr, src1_addr, src2_addr;
    logic        issue, busy, done, err;
    logic [7:0]  pc;

    logic [27:0] rom [256];
    iss_t        exp_q[$];
    iss_t        obs_q[$];
    logic [3:0]  op_trace [64];
    int          done_cyc;
    logic        err_at_done;
    logic [7:0]  pc_at_done;
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [27:0] W_HALT = {4'h8, 24'h0};
    localparam logic [27:0] W_NOP  = {4'hF, 24'h0};

    inst_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .abort      (abort),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .opcode_o   (opcode_o),
        .dest_addr  (dest_addr),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .issue      (issue),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

    task automatic drive_start(input logic [7:0] spc);
        @(negedge clk);
        start    = 1'b1;
        start_pc = spc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observes cycles 1..max after the start edge; records issues and the done pulse.
    task automatic run_to_done(input int max);
        done_cyc = -1;
        obs_q.delete();
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (c < 64) op_trace[c] = opcode_o;
            if (issue) obs_q.push_back('{c, opcode_o, dest_addr, src1_addr, src2_addr});
            if (done) begin
                done_cyc    = c;
                err_at_done = err;
                pc_at_done  = pc;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({imem_en, issue, busy, done, err} !== 5'b0 || opcode_o !== 4'hF || pc !== 8'h00 ||
            dest_addr !== 8'h00 || src1_addr !== 8'h00 || src2_addr !== 8'h00 || imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: en=%b iss=%b busy=%b done=%b err=%b op=%h pc=%h d=%h s1=%h s2=%h, required zeros and op=f",
                     imem_en, issue, busy, done, err, opcode_o, pc, dest_addr, src1_addr, src2_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_op;
        exp_q.delete();
        drive_start(8'h10);
        exp_q.push_back('{3, 4'h0, 8'h05, 8'h01, 8'h02});
        run_to_done(40);
        n_tests++;
        if (done_cyc !== 8) begin n_fail++; $display("FAIL single_done_cycle: got %0d required 8", done_cyc); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_issue_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end else begin
            while (exp_q.size() > 0) begin
                iss_t e = exp_q.pop_front();
                iss_t o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL single_issue: got cyc=%0d op=%h d=%h s1=%h s2=%h required cyc=%0d op=%h d=%h s1=%h s2=%h",
                             o.cyc, o.op, o.d, o.s1, o.s2, e.cyc, e.op, e.d, e.s1, e.s2);
                end
            end
        end
        n_tests++;
        if (op_trace[4] !== 4'h0 || op_trace[5] !== 4'hF) begin
            n_fail++; $display("FAIL single_exec_window: op@4=%h op@5=%h required 0 and f", op_trace[4], op_trace[5]);
        end
        n_tests++;
        if (done_cyc == 8 && (err_at_done !== 1'b0 || pc_at_done !== 8'h11)) begin
            n_fail++; $display("FAIL single_end_state: err=%b pc=%h required 0 and 11", err_at_done, pc_at_done);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_after: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_nop_skip;
        logic bad;
        drive_start(8'h00);
        run_to_done(40);
        n_tests++;
        if (done_cyc !== 9) begin n_fail++; $display("FAIL nop_done_cycle: got %0d required 9", done_cyc); end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL nop_issue_count: got %0d required 0", obs_q.size()); end
        bad = 1'b0;
        for (int c = 1; c <= 9 && c <= done_cyc; c++) if (op_trace[c] !== 4'hF) bad = 1'b1;
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL nop_opcode_idle: opcode left f (got 1) required 0"); end
    endtask

    task automatic test_end_of_rom;
        drive_start(8'hFF);
        exp_q.delete();
        exp_q.push_back('{3, 4'h2, 8'h0A, 8'h0B, 8'h0C});
        run_to_done(40);
        n_tests++;
        if (done_cyc !== 6 || err_at_done !== 1'b1 || pc_at_done !== 8'hFF) begin
            n_fail++;
            $display("FAIL eor_end: done@%0d err=%b pc=%h required done@6 err=1 pc=ff", done_cyc, err_at_done, pc_at_done);
        end
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL eor_issue: got %0d issues (op %h) required 1 issue of op 2",
                               obs_q.size(), obs_q.size() > 0 ? obs_q[0].op : 4'hx);
        end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL eor_err_sticky: got %b required 1", err); end
        drive_start(8'h20);
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL eor_err_clear: got %b required 0", err); end
        run_to_done(20);
    endtask

    task automatic test_abort;
        drive_start(8'h30);
        repeat (4) @(negedge clk);
        n_tests++;
        if (opcode_o !== 4'h2 || issue !== 1'b0) begin
            n_fail++; $display("FAIL abort_pre: op=%h issue=%b required 2 0", opcode_o, issue);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (opcode_o !== 4'hF || done !== 1'b1 || pc !== 8'h30) begin
            n_fail++; $display("FAIL abort_done: op=%h done=%b pc=%h required f 1 30", opcode_o, done, pc);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done);
        end
        drive_start(8'h10);
        run_to_done(40);
        n_tests++;
        if (done_cyc !== 8 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL abort_rerun: done@%0d issues=%0d required done@8 issues=1", done_cyc, obs_q.size());
        end
    endtask

    task automatic test_rst_mid_run;
        logic saw_done;
        drive_start(8'h30);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        start_pc = 8'h50;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (pc !== 8'h30 || issue !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_ignored: pc=%h issue=%b required 30 1", pc, issue);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || pc !== 8'h00 || done !== 1'b0 || opcode_o !== 4'hF) begin
            n_fail++; $display("FAIL rst_mid: busy=%b pc=%h done=%b op=%h required 0 00 0 f", busy, pc, done, opcode_o);
        end
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL rst_quiet: activity after reset got 1 required 0"); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = W_HALT;
        rom[8'h00] = W_NOP;
        rom[8'h01] = {4'h9, 24'h0};
        rom[8'h02] = W_HALT;
        rom[8'h10] = {4'h0, 8'h05, 8'h01, 8'h02};
        rom[8'h11] = W_HALT;
        rom[8'h30] = {4'h2, 8'h07, 8'h08, 8'h09};
        rom[8'h31] = W_HALT;
        rom[8'hFF] = {4'h2, 8'h0A, 8'h0B, 8'h0C};
        test_reset();
        test_single_op();
        test_nop_skip();
        test_end_of_rom();
        test_abort();
        test_rst_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
